op_token_queue: RTL and testbench
=================================

OP_TOKEN_QUEUE -- requirements
Module: op_token_queue

Interface
REQ-001 Parameter DEPTH, default 2, number of token entries; legal range 1..16.
REQ-002 Parameter DATA_W, default 128, payload width (opA|opB|opC|NPC packed, plus instruction/xu fields as needed).
REQ-003 Parameter TAG_W, default 4, stream-tag width.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  producer (operand fetch) offers a token.
REQ-007 in_ready  output  1  queue accepts a token this cycle.
REQ-008 in_data  input  DATA_W  token payload.
REQ-009 in_tag  input  TAG_W  stream tag of the token.
REQ-010 out_valid  output  1  head token is live and presented to execute.
REQ-011 out_ready  input  1  execute consumes the head token.
REQ-012 out_data  output  DATA_W  head payload.
REQ-013 out_tag  output  TAG_W  head tag.
REQ-014 flush  input  1  stream redirect (taken jump) notification.
REQ-015 flush_tag  input  TAG_W  new current stream tag accompanying flush.
REQ-016 count  output  $clog2(DEPTH+1)  occupied entries, live and killed.

Function
REQ-017 Storage: circular buffer of DEPTH entries, each {data, tag, live}; head and tail pointers wrap from DEPTH-1 to 0 for any DEPTH, not only powers of two.
REQ-018 in_ready = (count < DEPTH); depends only on registered state, no combinational path from out_ready.
REQ-019 Push when in_valid && in_ready: entry written at tail, live=1, tail advances, count increments.
REQ-020 No fall-through: token pushed in cycle N is visible at the head no earlier than cycle N+1.
REQ-021 out_valid = (count != 0) && head.live; out_data/out_tag are driven from the head entry whenever count != 0, else zero.
REQ-022 Pop when out_valid && out_ready: head advances, count decrements.
REQ-023 Auto-drop: when count != 0 and head.live == 0, head advances and count decrements without asserting out_valid, one killed entry per cycle, regardless of out_ready.
REQ-024 Flush: on a cycle with flush=1, every stored entry with tag != flush_tag gets live=0 at that edge; entries with tag == flush_tag remain live.
REQ-025 Simultaneous flush and push: the incoming token is written with live = (in_tag == flush_tag).
REQ-026 Simultaneous flush and pop: the pop of the current head completes as in REQ-022, since out_valid was already asserted that cycle; execute handles tag mismatch at retire.
REQ-027 Simultaneous push and pop/drop: count unchanged; both pointers advance.
REQ-028 When full (count == DEPTH), in_ready=0 even if a pop occurs that cycle; the push is accepted the following cycle.
REQ-029 Token order preserved; live tokens leave in push order; no token is duplicated.
REQ-030 Producer rule: in_data/in_tag held stable while in_valid && !in_ready; the queue does not depend on it but the bench checks it.

Reset
REQ-031 reset low asynchronously clears head=0, tail=0, count=0, all live bits=0; outputs immediately read out_valid=0, in_ready=1, out_data=0, out_tag=0, count=0.
REQ-032 Reset asserted mid-operation discards all tokens; no token pushed before reset appears after deassertion.
REQ-033 Entry data/tag storage need not be reset; only control state is reset.

Verification
REQ-034 DEPTH=2: push A (tag 3), B (tag 3), with out_ready=0 -> count=2, in_ready=0; assert out_ready -> A popped next cycle, then B; count returns to 0.
REQ-035 DEPTH=3: fill with tags 1,1,2; flush with flush_tag=2 -> head entries tag 1 dropped over 2 cycles with out_valid=0, then the tag 2 token is presented with out_valid=1.
REQ-036 Flush with flush_tag=5 and same-cycle push of tag 4 -> the token is written killed and later auto-dropped; a push with tag 5 is kept.
REQ-037 Full queue with out_ready=1 and in_valid=1 -> in_ready=0 that cycle, push accepted next cycle, count never exceeds DEPTH.
REQ-038 DEPTH=3 continuous push/pop for 10 tokens -> pointers wrap, output order equals input order, count steady.
REQ-039 Assert reset with count=2 mid-stream -> out_valid=0 and count=0 immediately; after release, first pushed token appears first.

Source files
------------

// File: rtl/op_token_queue_if.sv
// Token handshake bundle between operand fetch, the token queue and execute.
// slave is the queue side; master is the producer/consumer side.
interface op_token_queue_if #(
  parameter int DATA_W = 128,
  parameter int TAG_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;
  logic              flush;
  logic [TAG_W-1:0]  flush_tag;

  modport slave (
    input  in_valid, in_data, in_tag,
    input  out_ready, flush, flush_tag,
    output in_ready, out_valid,
    output out_data, out_tag
  );

  modport master (
    output in_valid, in_data, in_tag,
    output out_ready, flush, flush_tag,
    input  in_ready, out_valid,
    input  out_data, out_tag
  );
endinterface

// File: rtl/op_token_queue.sv
// Operand token queue between operand fetch and execute.
// Flushed tokens stay in place as dead entries and drain one per cycle.
module op_token_queue #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 128,
  parameter int TAG_W  = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  op_token_queue_if.slave q,
  output logic [CW-1:0] count
);
  localparam int PW =
    (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST =
    PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL =
    CW'(DEPTH);

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [DEPTH-1:0]  live_q;
  logic [DEPTH-1:0]  live_d;
  logic [PW-1:0]     head_q;
  logic [PW-1:0]     tail_q;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_d;
  logic              nonempty;
  logic              head_live;
  logic              push;
  logic              pop;
  logic              drop;
  logic              deq;

  function automatic logic [PW-1:0] bump(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign nonempty  = count_q != '0;
  assign head_live = live_q[head_q];

  assign q.in_ready  = count_q < FULL;
  assign q.out_valid = nonempty && head_live;
  assign q.out_data  =
    nonempty ? data_q[head_q] : '0;
  assign q.out_tag   =
    nonempty ? tag_q[head_q] : '0;
  assign count       = count_q;

  assign push = q.in_valid && q.in_ready;
  assign pop  = q.out_valid && q.out_ready;
  assign drop = nonempty && !head_live;
  assign deq  = pop || drop;

  // An incoming token is killed on the spot
  // if it already belongs to the stale stream.
  always_comb begin
    live_d = live_q;
    if (q.flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (tag_q[i] != q.flush_tag)
          live_d[i] = 1'b0;
      end
    end
    if (push)
      live_d[tail_q] = !q.flush ||
        (q.in_tag == q.flush_tag);
  end

  always_comb begin
    count_d = count_q;
    unique case (1'b1)
      push && !deq: count_d = count_q + 1'b1;
      !push && deq: count_d = count_q - 1'b1;
      default:      count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      live_q  <= '0;
    end else begin
      live_q  <= live_d;
      count_q <= count_d;
      if (push) tail_q <= bump(tail_q);
      if (deq)  head_q <= bump(head_q);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_q[tail_q] <= q.in_data;
      tag_q[tail_q]  <= q.in_tag;
    end
  end
endmodule

// File: tb/tb_op_token_queue.sv
// Directed bench for op_token_queue.
// DEPTH=2 and DEPTH=3 instances share clock and reset.
module tb_op_token_queue;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [1:0] count2;
  logic [1:0] count3;
  int n_assert = 0;
  int n_fail = 0;

  localparam logic [127:0] TA = 128'hA0A0_0001;
  localparam logic [127:0] TB = 128'hB0B0_0002;
  localparam logic [127:0] TC = 128'hC0C0_0003;
  localparam logic [127:0] TD = 128'hD0D0_0004;
  localparam logic [127:0] TE = 128'hE0E0_0005;
  localparam logic [127:0] TF = 128'hF0F0_0006;
  localparam logic [127:0] TG = 128'h1717_0007;
  localparam logic [127:0] TH = 128'h2828_0008;
  localparam logic [127:0] TP = 128'h3939_0009;
  localparam logic [127:0] TQ = 128'h4A4A_000A;
  localparam logic [127:0] TR = 128'h5B5B_000B;
  localparam logic [127:0] TS = 128'h6C6C_000C;
  localparam logic [127:0] TT = 128'h7D7D_000D;

  always #5 clk = ~clk;

  op_token_queue_if #(.DATA_W(128), .TAG_W(4)) a ();
  op_token_queue_if #(.DATA_W(128), .TAG_W(4)) b ();

  op_token_queue #(
    .DEPTH(2), .DATA_W(128), .TAG_W(4)
  ) u2 (
    .clk(clk), .reset(reset),
    .q(a.slave), .count(count2)
  );

  op_token_queue #(
    .DEPTH(3), .DATA_W(128), .TAG_W(4)
  ) u3 (
    .clk(clk), .reset(reset),
    .q(b.slave), .count(count3)
  );

  task automatic chk(
    input string        tag,
    input logic [127:0] obs,
    input logic [127:0] exp
  );
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a.in_valid = 0; a.in_data = '0; a.in_tag = '0;
    a.out_ready = 0; a.flush = 0; a.flush_tag = '0;
    b.in_valid = 0; b.in_data = '0; b.in_tag = '0;
    b.out_ready = 0; b.flush = 0; b.flush_tag = '0;
    #1;
    chk("rst_out_valid", a.out_valid, 0);
    chk("rst_in_ready", a.in_ready, 1);
    chk("rst_out_data", a.out_data, 0);
    chk("rst_out_tag", a.out_tag, 0);
    chk("rst_count2", count2, 0);
    chk("rst_count3", count3, 0);
    tick(); tick();
    @(negedge clk) reset = 1'b1;
    tick();

    // fill DEPTH=2 with A,B then drain
    a.in_valid = 1; a.in_data = TA; a.in_tag = 3;
    #1;
    chk("nofall_valid", a.out_valid, 0);
    chk("push_ready", a.in_ready, 1);
    tick();
    chk("one_count", count2, 1);
    chk("one_data", a.out_data, TA);
    a.in_data = TB;
    tick();
    a.in_valid = 0;
    #1;
    chk("full_count", count2, 2);
    chk("full_ready", a.in_ready, 0);
    chk("full_head", a.out_data, TA);
    chk("full_tag", a.out_tag, 3);
    a.out_ready = 1;
    tick();
    chk("popA_count", count2, 1);
    chk("popA_head", a.out_data, TB);
    tick();
    chk("popB_count", count2, 0);
    chk("popB_valid", a.out_valid, 0);
    chk("empty_data", a.out_data, 0);
    a.out_ready = 0;

    // full with pop and push offered together
    a.in_valid = 1; a.in_data = TC;
    tick();
    a.in_data = TD;
    tick();
    a.in_data = TE; a.out_ready = 1;
    #1;
    chk("fullpop_ready", a.in_ready, 0);
    tick();
    chk("fullpop_count", count2, 1);
    chk("fullpop_head", a.out_data, TD);
    chk("fullpop_ready2", a.in_ready, 1);
    tick();
    chk("pushpop_count", count2, 1);
    chk("pushpop_head", a.out_data, TE);
    a.in_valid = 0;
    tick();
    chk("drainE_count", count2, 0);
    a.out_ready = 0;

    // DEPTH=3 fill tags 1,1,2 then flush to 2
    b.in_valid = 1; b.in_data = TP; b.in_tag = 1;
    tick();
    b.in_data = TQ;
    tick();
    b.in_data = TR; b.in_tag = 2;
    tick();
    b.in_valid = 0;
    #1;
    chk("f3_count", count3, 3);
    chk("f3_ready", b.in_ready, 0);
    chk("f3_valid_pre", b.out_valid, 1);
    b.flush = 1; b.flush_tag = 2;
    tick();
    b.flush = 0;
    #1;
    chk("f3_dead0_valid", b.out_valid, 0);
    chk("f3_dead0_count", count3, 3);
    tick();
    chk("f3_dead1_valid", b.out_valid, 0);
    chk("f3_dead1_count", count3, 2);
    tick();
    chk("f3_live_valid", b.out_valid, 1);
    chk("f3_live_count", count3, 1);
    chk("f3_live_data", b.out_data, TR);
    chk("f3_live_tag", b.out_tag, 2);
    b.out_ready = 1;
    tick();
    chk("f3_empty", count3, 0);
    b.out_ready = 0;

    // flush with same-cycle push of a stale tag
    b.flush = 1; b.flush_tag = 5;
    b.in_valid = 1; b.in_data = TS; b.in_tag = 4;
    tick();
    b.flush = 0; b.in_data = TT; b.in_tag = 5;
    #1;
    chk("fp_count", count3, 1);
    chk("fp_killed", b.out_valid, 0);
    tick();
    b.in_valid = 0;
    #1;
    chk("fp_keep_count", count3, 1);
    chk("fp_keep_valid", b.out_valid, 1);
    chk("fp_keep_data", b.out_data, TT);
    chk("fp_keep_tag", b.out_tag, 5);
    b.out_ready = 1;
    tick();
    chk("fp_empty", count3, 0);

    // streaming through DEPTH=3, pointers wrap
    b.in_valid = 1; b.in_tag = 7;
    for (int i = 0; i < 10; i++) begin
      b.in_data = 128'(100 + i);
      #1;
      if (i > 0) begin
        chk("stream_data", b.out_data,
            128'(100 + i - 1));
        chk("stream_count", count3, 1);
      end
      tick();
    end
    b.in_valid = 0;
    #1;
    chk("stream_last", b.out_data, 128'(109));
    tick();
    chk("stream_empty", count3, 0);
    b.out_ready = 0;

    // reset mid-stream discards stored tokens
    a.in_valid = 1; a.in_data = TF; a.in_tag = 1;
    tick();
    a.in_data = TG;
    tick();
    a.in_valid = 0;
    #1;
    chk("pre_rst_count", count2, 2);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", a.out_valid, 0);
    chk("mid_rst_count", count2, 0);
    chk("mid_rst_ready", a.in_ready, 1);
    chk("mid_rst_data", a.out_data, 0);
    @(negedge clk) reset = 1'b1;
    a.in_valid = 1; a.in_data = TH; a.in_tag = 2;
    tick();
    a.in_valid = 0;
    #1;
    chk("post_rst_count", count2, 1);
    chk("post_rst_head", a.out_data, TH);
    a.out_ready = 1;
    tick();
    chk("post_rst_empty", count2, 0);
    chk("post_rst_valid", a.out_valid, 0);
    a.out_ready = 0;

    $display(
      "End of test - %0d assertions evaluated, %0d failures",
      n_assert, n_fail);
    $finish;
  end
endmodule
